// File: rtl/sort4_seq_pkg.sv
// Shared definitions for the sequential 4-element sorter: sizes, FSM states,
// and the fixed compare-pair schedule driven by the step counter.
package sort4_seq_pkg;

    localparam int W = 4;
    localparam int N = 4;
    localparam logic [2:0] LAST_STEP = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Lower index of the compared pair for steps 5..0 (MSB..LSB); the upper index is always lower+1.
    localparam logic [11:0] SCHED_LO = {2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

    function automatic logic [1:0] pair_lo(input logic [2:0] step);
        logic [1:0] lo;
        lo = 2'd0;
        if (step <= LAST_STEP) begin
            lo = SCHED_LO[{step, 1'b0} +: 2];
        end
        return lo;
    endfunction

endpackage

// File: rtl/sort4_seq_if.sv
// Loader/consumer handshake for the sorter: start request in, ordered result out.
interface sort4_seq_if;
    logic        start;
    logic        desc;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [2:0]  swap_cnt;

    modport master (
        output start, desc, din,
        input  busy, done, dout, swap_cnt
    );

    modport slave (
        input  start, desc, din,
        output busy, done, dout, swap_cnt
    );
endinterface

// File: rtl/sort4_seq_cmp4_unit.sv
// Combinational unsigned 4-bit magnitude comparator, shared by every sort step.
module cmp4_unit
    import sort4_seq_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt,
    output logic         sm
);
    assign eq = (a == b);
    assign gt = (a > b);
    assign sm = (a < b);
endmodule

// File: rtl/sort4_seq.sv
// Sequential bubble sorter: four 4-bit elements, one compare/swap per cycle over
// a fixed six-step schedule, result published one cycle after the last step.
module sort4_seq
    import sort4_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    sort4_seq_if.slave  bus
);
    state_t                state_reg, state_next;
    logic [2:0]            step_reg, step_next;
    logic                  mode_reg, mode_next;
    logic [2:0]            cnt_reg, cnt_next;
    logic [N-1:0][W-1:0]   r_reg, r_next;
    logic [N*W-1:0]        dout_reg, dout_next;
    logic [2:0]            swap_cnt_reg, swap_cnt_next;

    logic                  load;
    logic [1:0]            lo_idx, hi_idx;
    logic [W-1:0]          op_a, op_b;
    logic                  cmp_eq, cmp_gt, cmp_sm;
    logic                  do_swap;

    assign lo_idx = pair_lo(step_reg);
    assign hi_idx = lo_idx + 2'd1;
    assign op_a   = r_reg[lo_idx];
    assign op_b   = r_reg[hi_idx];

    cmp4_unit u_cmp (
        .a  (op_a),
        .b  (op_b),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .sm (cmp_sm)
    );

    // Equal operands never swap, which keeps the sort stable in both directions.
    assign do_swap = (state_reg == S_SORT) && !cmp_eq && (mode_reg ? cmp_sm : cmp_gt);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            assign r_next[gi] = load                              ? bus.din[gi*W +: W] :
                                (do_swap && (lo_idx == 2'(gi)))   ? op_b :
                                (do_swap && (hi_idx == 2'(gi)))   ? op_a :
                                                                    r_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        step_next     = step_reg;
        mode_next     = mode_reg;
        cnt_next      = cnt_reg;
        dout_next     = dout_reg;
        swap_cnt_next = swap_cnt_reg;
        load          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    mode_next  = bus.desc;
                    step_next  = 3'd0;
                    cnt_next   = 3'd0;
                    state_next = S_SORT;
                end
            end
            S_SORT: begin
                step_next = step_reg + 3'd1;
                if (do_swap) begin
                    cnt_next = cnt_reg + 3'd1;
                end
                if (step_reg == LAST_STEP) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                dout_next     = r_reg;
                swap_cnt_next = cnt_reg;
                state_next    = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            step_reg     <= 3'd0;
            mode_reg     <= 1'b0;
            cnt_reg      <= 3'd0;
            r_reg        <= '0;
            dout_reg     <= '0;
            swap_cnt_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            step_reg     <= step_next;
            mode_reg     <= mode_next;
            cnt_reg      <= cnt_next;
            r_reg        <= r_next;
            dout_reg     <= dout_next;
            swap_cnt_reg <= swap_cnt_next;
        end
    end

    assign bus.busy     = (state_reg == S_SORT);
    assign bus.done     = (state_reg == S_DONE);
    assign bus.dout     = dout_reg;
    assign bus.swap_cnt = swap_cnt_reg;

endmodule

// File: tb/tb_sort4_seq.sv
// Self-checking bench for sort4_seq: directed table, handshake corner cases,
// and random vectors against a counting-sort / inversion-count reference.
module tb_sort4_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sort4_seq_if bus ();

    sort4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [15:0] din;
        logic        desc;
        logic [15:0] exp_dout;
        logic [2:0]  exp_swaps;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: sorted order via value histogram, swaps = number of strict inversions.
    task automatic model(input logic [15:0] din_v, input logic desc_v,
                         output logic [15:0] exp_dout, output logic [2:0] exp_swaps);
        int e[4];
        int hist[16];
        int k;
        int inv;
        for (int i = 0; i < 4; i++) e[i] = int'(din_v[i*4 +: 4]);
        for (int v = 0; v < 16; v++) hist[v] = 0;
        for (int i = 0; i < 4; i++) hist[e[i]]++;
        k = 0;
        exp_dout = 16'h0;
        for (int v = 0; v < 16; v++) begin
            for (int c = 0; c < hist[v]; c++) begin
                if (desc_v) exp_dout[(3-k)*4 +: 4] = 4'(v);
                else        exp_dout[k*4 +: 4]     = 4'(v);
                k++;
            end
        end
        inv = 0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (desc_v ? (e[i] < e[j]) : (e[i] > e[j])) inv++;
        exp_swaps = 3'(inv);
    endtask

    // Issues one start and follows the sort to its result; optionally pulses start mid-sort.
    task automatic run_sort(input logic [15:0] din_v, input logic desc_v, input bit inject,
                            output logic [15:0] got_dout, output logic [2:0] got_swaps,
                            output int done_at, output int done_abs, output int busy_cycles,
                            output bit stable_ok, output logic done_after);
        logic [15:0] prev;
        int cyc;
        cyc = 0;
        @(negedge clk);
        prev      = bus.dout;
        bus.start = 1'b1;
        bus.desc  = desc_v;
        bus.din   = din_v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.din   = ~din_v;
        bus.desc  = ~desc_v;
        done_at = -1;
        done_abs = -1;
        busy_cycles = 0;
        stable_ok = 1'b1;
        while (cyc < 20 && done_at < 0) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) busy_cycles++;
            if (bus.dout !== prev) stable_ok = 1'b0;
            if (bus.done === 1'b1) begin
                done_at  = cyc;
                done_abs = cyc_cnt;
            end
            if (inject && cyc == 3) begin
                bus.start = 1'b1;
                bus.din   = 16'h1111;
            end
            if (inject && cyc == 4) bus.start = 1'b0;
        end
        @(posedge clk);
        #1;
        got_dout   = bus.dout;
        got_swaps  = bus.swap_cnt;
        done_after = bus.done;
    endtask

    task automatic sort_and_check(input string tag, input logic [15:0] din_v, input logic desc_v,
                                  input bit inject, input logic [15:0] exp_dout,
                                  input logic [2:0] exp_swaps, output int done_abs);
        logic [15:0] got_dout;
        logic [2:0]  got_swaps;
        int done_at, busy_cycles;
        bit stable_ok;
        logic done_after;
        run_sort(din_v, desc_v, inject, got_dout, got_swaps, done_at, done_abs,
                 busy_cycles, stable_ok, done_after);
        check({tag, " dout"}, 32'(got_dout), 32'(exp_dout));
        check({tag, " swap_cnt"}, 32'(got_swaps), 32'(exp_swaps));
        check({tag, " done_latency"}, 32'(done_at), 32'd7);
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'd6);
        check({tag, " dout_stable"}, 32'(stable_ok), 32'd1);
        check({tag, " done_one_cycle"}, 32'(done_after), 32'd0);
        $display("sort %s din=%h desc=%0d -> dout=%h swaps=%0d latency=%0d",
                 tag, din_v, desc_v, got_dout, got_swaps, done_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int d_abs, d_abs2;
        int done_seen;
        logic [15:0] m_dout;
        logic [2:0]  m_swaps;
        logic [15:0] rnd_din;
        logic        rnd_desc;

        tbl[0] = '{16'h3142, 1'b0, 16'h4321, 3'd3};
        tbl[1] = '{16'h3142, 1'b1, 16'h1234, 3'd3};
        tbl[2] = '{16'h0123, 1'b0, 16'h3210, 3'd6};
        tbl[3] = '{16'h7777, 1'b0, 16'h7777, 3'd0};
        tbl[4] = '{16'h0123, 1'b1, 16'h0123, 3'd0};
        tbl[5] = '{16'hF0F0, 1'b1, 16'h00FF, 3'd3};

        bus.start = 1'b0;
        bus.desc  = 1'b0;
        bus.din   = 16'h0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset dout", 32'(bus.dout), 32'd0);
        check("reset swap_cnt", 32'(bus.swap_cnt), 32'd0);
        $display("reset: busy=%0d done=%0d dout=%h swaps=%0d", bus.busy, bus.done, bus.dout, bus.swap_cnt);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sort_and_check($sformatf("tbl%0d", i), tbl[i].din, tbl[i].desc, 1'b0,
                           tbl[i].exp_dout, tbl[i].exp_swaps, d_abs);
        end

        // Back-to-back: each start lands in the IDLE cycle right after DONE.
        sort_and_check("b2b_a", 16'h0123, 1'b0, 1'b0, 16'h3210, 3'd6, d_abs);
        sort_and_check("b2b_b", 16'h3142, 1'b0, 1'b0, 16'h4321, 3'd3, d_abs2);
        check("b2b done spacing", 32'(d_abs2 - d_abs), 32'd8);
        $display("b2b: done pulses %0d cycles apart", d_abs2 - d_abs);

        // Start pulsed during SORT with other data must be ignored.
        sort_and_check("ignore_start", 16'hF0F0, 1'b0, 1'b1, 16'hFF00, 3'd1, d_abs);
        check("ignore_start idle busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("ignore_start idle busy next", 32'(bus.busy), 32'd0);

        // Reset at SORT step 3.
        @(negedge clk);
        bus.start = 1'b1;
        bus.desc  = 1'b0;
        bus.din   = 16'h3142;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset dout", 32'(bus.dout), 32'd0);
        check("midreset swap_cnt", 32'(bus.swap_cnt), 32'd0);
        $display("midreset: busy=%0d done=%0d dout=%h swaps=%0d", bus.busy, bus.done, bus.dout, bus.swap_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        check("midreset no activity", 32'(done_seen), 32'd0);
        sort_and_check("after_reset", 16'h3142, 1'b0, 1'b0, 16'h4321, 3'd3, d_abs);

        for (int i = 0; i < 40; i++) begin
            rnd_din  = 16'($urandom);
            rnd_desc = 1'($urandom_range(0, 1));
            model(rnd_din, rnd_desc, m_dout, m_swaps);
            sort_and_check($sformatf("rnd%0d", i), rnd_din, rnd_desc, 1'b0, m_dout, m_swaps, d_abs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
